// File: rtl/pwm_3ph_deadtime.sv
// pwm_3ph_deadtime: three-leg sawtooth PWM with per-leg dead-time insertion and a
// double-buffered duty update that takes effect at the carrier wrap (cnt_in == 0).
// Optional feature: define PWM_FAULT_LATCH_EN to enable the synchronised, latched
// fault trip; without it the fault inputs are ignored and fault_latched is 0.

module pwm_3ph_deadtime #(
    parameter int CARRIER_TOP = 9999,
    parameter int DEAD        = 50
) (
    input  logic        clkin,
    input  logic        global_rst,
    input  logic [15:0] cnt_in,
    input  logic [15:0] duty_a,
    input  logic [15:0] duty_b,
    input  logic [15:0] duty_c,
    input  logic        duty_valid,
    output logic        duty_ready,
    input  logic        fault,
    input  logic        fault_clr,
    output logic        pwm_ah,
    output logic        pwm_al,
    output logic        pwm_bh,
    output logic        pwm_bl,
    output logic        pwm_ch,
    output logic        pwm_cl,
    output logic        fault_latched
);

    // Largest meaningful duty: one past the carrier top gives a permanently high request.
    localparam logic [15:0] DUTY_MAX = 16'(CARRIER_TOP + 1);
    localparam logic [7:0]  DEAD_CNT = 8'(DEAD);

    typedef enum logic [1:0] {
        S_DEAD,
        S_HI_ON,
        S_LO_ON
    } leg_state_t;

    // Leg index 0 = phase a, 1 = phase b, 2 = phase c.
    logic [2:0][15:0] duty_in;
    assign duty_in = {duty_c, duty_b, duty_a};

    logic [2:0][15:0] stage_q, stage_d;
    logic [2:0][15:0] shadow_q, shadow_d;
    logic             pending_q, pending_d;
    logic             ready_q, ready_d;
    logic             take;
    logic [2:0]       req;
    logic             fault_hold;

    leg_state_t       state_q [3];
    leg_state_t       state_d [3];
    logic [7:0]       dcnt_q  [3];
    logic [7:0]       dcnt_d  [3];
    logic [2:0]       pwm_h_q, pwm_h_d;
    logic [2:0]       pwm_l_q, pwm_l_d;

    // Duty handshake into staging, and staging-to-shadow transfer at the carrier wrap.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        stage_d   = stage_q;
        shadow_d  = shadow_q;
        pending_d = pending_q;
        take      = duty_valid && !pending_q;
        // Only an update that was already pending before this wrap cycle is transferred;
        // a handshake taken in the wrap cycle itself waits for the next wrap.
        if ((cnt_in == 16'd0) && pending_q) begin
            shadow_d  = stage_q;
            pending_d = 1'b0;
        end
        if (take) begin
            for (int i = 0; i < 3; i++) begin
                stage_d[i] = (duty_in[i] > DUTY_MAX) ? DUTY_MAX : duty_in[i];
            end
            pending_d = 1'b1;
        end
        ready_d = !pending_d;
    end

    // Raw per-leg request; compares against shadow_d so the period that starts at the
    // wrap already uses the freshly transferred duty, including its cnt_in == 0 cycle.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            req[i] = (cnt_in < shadow_d[i]);
        end
    end

`ifdef PWM_FAULT_LATCH_EN
    logic fault_s1_q, fault_s2_q;
    logic fault_latched_q, fault_latched_d;

    // Trip latch: a synchronised fault sets it; a clear is honoured only once the fault is gone.
    always_comb begin
        fault_latched_d = fault_latched_q;
        if (fault_s2_q) begin
            fault_latched_d = 1'b1;
        end else if (fault_clr) begin
            fault_latched_d = 1'b0;
        end
    end

    // Two-flop synchroniser for the asynchronous fault input, plus the trip latch flop.
    always_ff @(posedge clkin or posedge global_rst) begin
        if (global_rst) begin
            fault_s1_q      <= 1'b0;
            fault_s2_q      <= 1'b0;
            fault_latched_q <= 1'b0;
        end else begin
            fault_s1_q      <= fault;
            fault_s2_q      <= fault_s1_q;
            fault_latched_q <= fault_latched_d;
        end
    end

    // Legs are parked in DEAD (counter reloaded) for as long as the trip is active, so the
    // clear cycle releases them into a full dead interval.
    assign fault_hold    = fault_s2_q || fault_latched_q;
    assign fault_latched = fault_latched_q;
`else
    logic unused_fault;
    assign unused_fault  = fault ^ fault_clr;
    assign fault_hold    = 1'b0;
    assign fault_latched = 1'b0;
`endif

    // Per-leg dead-time FSM: any request change from a settled state inserts DEAD off cycles;
    // the target is sampled only when the dead counter expires.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            state_d[i] = state_q[i];
            dcnt_d[i]  = dcnt_q[i];
            if (fault_hold) begin
                state_d[i] = S_DEAD;
                dcnt_d[i]  = DEAD_CNT;
            end else begin
                case (state_q[i])
                    S_HI_ON: begin
                        if (!req[i]) begin
                            state_d[i] = S_DEAD;
                            dcnt_d[i]  = DEAD_CNT;
                        end
                    end
                    S_LO_ON: begin
                        if (req[i]) begin
                            state_d[i] = S_DEAD;
                            dcnt_d[i]  = DEAD_CNT;
                        end
                    end
                    default: begin
                        if (dcnt_q[i] <= 8'd1) begin
                            state_d[i] = req[i] ? S_HI_ON : S_LO_ON;
                        end else begin
                            dcnt_d[i] = dcnt_q[i] - 8'd1;
                        end
                    end
                endcase
            end
            // Drives decode from the next state so they are registered alongside it.
            pwm_h_d[i] = (state_d[i] == S_HI_ON);
            pwm_l_d[i] = (state_d[i] == S_LO_ON);
        end
    end

    // State register for the duty buffers, handshake and all three legs.
    always_ff @(posedge clkin or posedge global_rst) begin
        if (global_rst) begin
            stage_q   <= '0;
            shadow_q  <= '0;
            pending_q <= 1'b0;
            ready_q   <= 1'b1;
            pwm_h_q   <= '0;
            pwm_l_q   <= '0;
            for (int i = 0; i < 3; i++) begin
                state_q[i] <= S_DEAD;
                dcnt_q[i]  <= DEAD_CNT;
            end
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            stage_q   <= stage_d;
            shadow_q  <= shadow_d;
            pending_q <= pending_d;
            ready_q   <= ready_d;
            pwm_h_q   <= pwm_h_d;
            pwm_l_q   <= pwm_l_d;
            for (int i = 0; i < 3; i++) begin
                state_q[i] <= state_d[i];
                dcnt_q[i]  <= dcnt_d[i];
            end
        end
    end

    assign duty_ready = ready_q;
    assign pwm_ah     = pwm_h_q[0];
    assign pwm_al     = pwm_l_q[0];
    assign pwm_bh     = pwm_h_q[1];
    assign pwm_bl     = pwm_l_q[1];
    assign pwm_ch     = pwm_h_q[2];
    assign pwm_cl     = pwm_l_q[2];

endmodule
